// File: rtl/cmp64_seq_pkg.sv
// Shared compare-unit definitions: opcodes, FSM states and result decode.
package cmp64_seq_pkg;
  localparam int XLEN = 64;

  localparam logic [1:0] CMP_SLT  = 2'b00;
  localparam logic [1:0] CMP_SLTU = 2'b01;
  localparam logic [1:0] CMP_SEQ  = 2'b10;
  localparam logic [1:0] CMP_SGE  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == CMP_SLT) || (op == CMP_SGE);
  endfunction

  function automatic logic cmp_res(input logic [1:0] op, input logic lt, input logic gt);
    logic r;
    case (op)
      CMP_SLT, CMP_SLTU: r = lt;
      CMP_SEQ:           r = !lt && !gt;
      default:           r = !lt;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/cmp64_seq_digit.sv
// Unsigned magnitude compare of one DIGIT_W-bit digit.
module cmp_digit #(
  parameter int DIGIT_W = 8
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  output logic               d_lt_o,
  output logic               d_gt_o
);
  assign d_lt_o = a_i < b_i;
  assign d_gt_o = a_i > b_i;
endmodule

// File: rtl/cmp64_seq.sv
// Iterative 64-bit compare: scans operands MS digit first, fixed latency
// of 64/DIGIT_W cycles, returns {63'b0, res} and a zero flag.
module cmp64_seq
  import cmp64_seq_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
  output logic        z_flag
);
  localparam int N  = XLEN / DIGIT_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  cmp_state_e  state_q, state_d;
  logic [63:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [1:0]  op_q, op_d;
  logic        lt_q, lt_d, gt_q, gt_d, z_q, z_d, ov_q, ov_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        d_lt, d_gt, res;
  logic [63:0] sgn;

  cmp_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a_i    (a_q[63 -: DIGIT_W]),
    .b_i    (b_q[63 -: DIGIT_W]),
    .d_lt_o (d_lt),
    .d_gt_o (d_gt)
  );

  // Flipping the sign bits maps signed order onto unsigned order.
  assign sgn = {is_signed_op(op), 63'b0};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    z_d     = z_q;
    ov_d    = ov_q;
    res     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_d     = in1 ^ sgn;
          b_d     = in2 ^ sgn;
          op_d    = op;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (!lt_q && !gt_q) begin
            lt_d = d_lt;
            gt_d = d_gt;
          end
          a_d   = a_q << DIGIT_W;
          b_d   = b_q << DIGIT_W;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            res     = cmp_res(op_q, lt_d, gt_d);
            out_d   = {63'b0, res};
            z_d     = !res;
            ov_d    = 1'b1;
            state_d = DONE;
          end
        end
        DONE: if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign out       = out_q;
  assign z_flag    = z_q;
endmodule

// File: tb/tb_cmp64_seq.sv
// Directed + random scoreboard bench for cmp64_seq at DIGIT_W = 8, 1, 64.
module tb_cmp64_seq;
  logic        clk, rst_n, flush;
  logic [63:0] in1, in2;
  logic [1:0]  op;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, z_flag;
  logic [63:0] outv [3];

  typedef struct {
    logic [63:0] o;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  int          ntests = 0;
  int          nfail  = 0;
  int          LAT [3] = '{8, 64, 1};
  logic [63:0] last_out;
  logic [63:0] corner [4] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

  cmp64_seq #(.DIGIT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out(outv[0]), .z_flag(z_flag[0]));
  cmp64_seq #(.DIGIT_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out(outv[1]), .z_flag(z_flag[1]));
  cmp64_seq #(.DIGIT_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out(outv[2]), .z_flag(z_flag[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_res(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    case (o)
      2'b00:   return $signed(a) < $signed(b);
      2'b01:   return a < b;
      2'b10:   return a == b;
      default: return $signed(a) >= $signed(b);
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the unit back in IDLE.
  task automatic do_op(input int k, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input int hold);
    exp_t e;
    int   cyc;
    check("in_ready_pre", 64'(in_ready[k]), 64'd1);
    in1 = a; in2 = b; op = o; in_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
    in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; op = 2'($urandom);
    e.o = {63'b0, ref_res(o, a, b)};
    e.z = (e.o == 64'b0);
    sb.push_back(e);
    check("in_ready_busy", 64'(in_ready[k]), 64'd0);
    cyc = 0;
    while (!out_valid[k] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 64'(cyc), 64'(LAT[k]));
    e = sb.pop_front();
    check("out", outv[k], e.o);
    check("z_flag", 64'(z_flag[k]), 64'(e.z));
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 64'(out_valid[k]), 64'd1);
      check("hold_out", outv[k], e.o);
      check("hold_in_ready", 64'(in_ready[k]), 64'd0);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    out_ready[k] = 1'b0;
    check("valid_drop", 64'(out_valid[k]), 64'd0);
    check("in_ready_post", 64'(in_ready[k]), 64'd1);
    check("out_kept", outv[k], e.o);
    last_out = e.o;
  endtask

  initial begin
    logic [63:0] a, b;
    logic [1:0]  o;
    int          cnt [3] = '{300, 60, 500};
    rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = '0;
    in1 = '0; in2 = '0; op = '0; last_out = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid", 64'(out_valid[0]), 64'd0);
    check("rst_out", outv[0], 64'd0);
    check("rst_z", 64'(z_flag[0]), 64'd1);
    check("rst_in_ready", 64'(in_ready[0]), 64'd1);

    do_op(0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);          // SLT -1 < 1
    // Reset mid-RUN: result 1 above must be wiped, nothing emitted.
    in1 = 64'd0; in2 = 64'd5; op = 2'b01; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_out", outv[0], 64'd0);
    check("midrst_z", 64'(z_flag[0]), 64'd1);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_out", 64'(out_valid[0]), 64'd0);

    do_op(0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);          // SLTU -> 0
    do_op(0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);          // SLT -> 1
    do_op(0, 2'b00, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    do_op(0, 2'b11, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    do_op(0, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 0);
    do_op(0, 2'b01, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF1, 5); // backpressure
    do_op(0, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);

    // Flush at RUN cycle 3 of an op that would produce 0; previous out (1) stays.
    in1 = 64'd5; in2 = 64'd3; op = 2'b01; in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready[0]), 64'd1);
    check("flush_valid", 64'(out_valid[0]), 64'd0);
    check("flush_out", outv[0], last_out);
    check("flush_z", 64'(z_flag[0]), 64'd0);
    repeat (10) @(negedge clk);
    check("flush_no_out", 64'(out_valid[0]), 64'd0);
    // in_valid together with flush is dropped.
    in_valid[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; flush = 1'b0;
    check("flush_acc_ready", 64'(in_ready[0]), 64'd1);
    repeat (10) @(negedge clk);
    check("flush_acc_valid", 64'(out_valid[0]), 64'd0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < cnt[k]; n++) begin
        a = {$urandom, $urandom};
        o = 2'($urandom);
        case ($urandom_range(0, 3))
          0: b = a;
          1: b = a ^ (64'd1 << $urandom_range(0, 63));
          2: b = {$urandom, $urandom};
          default: begin
            a = corner[$urandom_range(0, 3)];
            b = corner[$urandom_range(0, 3)];
          end
        endcase
        do_op(k, o, a, b, $urandom_range(0, 2));
      end
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
